// File: rtl/regfile_pkg.sv
// Shared widths, grant source encoding and writeback payload for the write arbiter.
package regfile_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned NREG      = 16;
    localparam int unsigned REG_SEL_W = 4;

    typedef enum logic {
        GRANT_ALU = 1'b0,
        GRANT_LD  = 1'b1
    } grant_src_t;

    typedef struct packed {
        logic [REG_SEL_W-1:0] rd;
        logic [XLEN-1:0]      data;
    } wb_req_t;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Writeback handshake bundle from the ALU and the load unit to the arbiter.
interface regfile_write_arbiter_if;
    import regfile_pkg::*;

    logic                 alu_valid;
    logic [REG_SEL_W-1:0] alu_rd;
    logic [XLEN-1:0]      alu_data;
    logic                 alu_ready;
    logic                 ld_valid;
    logic [REG_SEL_W-1:0] ld_rd;
    logic [XLEN-1:0]      ld_data;
    logic                 ld_ready;

    modport master (
        output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
        input  alu_ready, ld_ready
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
        output alu_ready, ld_ready
    );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter; the requester not granted last wins a tie.
module rr_arbiter2
    import regfile_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req_alu,
    input  logic req_ld,
    output logic gnt_alu,
    output logic gnt_ld
);

    grant_src_t last_q;
    grant_src_t last_d;

    // Last-grant state register; reset favours the load unit on the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= GRANT_ALU;
        end else begin
            last_q <= last_d;
        end
    end

    // Last-grant advances only when someone is actually granted.
    always_comb begin
        last_d = last_q;
        if (gnt_alu) begin
            last_d = GRANT_ALU;
        end else if (gnt_ld) begin
            last_d = GRANT_LD;
        end
    end

    // Grant decode; nothing is granted while reset is held.
    always_comb begin
        gnt_alu = 1'b0;
        gnt_ld  = 1'b0;
        if (!rst) begin
            if (req_alu && req_ld) begin
                if (last_q == GRANT_ALU) begin
                    gnt_ld = 1'b1;
                end else begin
                    gnt_alu = 1'b1;
                end
            end else begin
                gnt_alu = req_alu;
                gnt_ld  = req_ld;
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between ALU and load writeback,
// tracks outstanding loads per register and flags decode read hazards.
module regfile_write_arbiter
    import regfile_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    regfile_write_arbiter_if.slave wb,
    input  logic                 ld_issue,
    input  logic [REG_SEL_W-1:0] ld_issue_rd,
    input  logic [REG_SEL_W-1:0] rs1_sel,
    input  logic [REG_SEL_W-1:0] rs2_sel,
    output logic                 hazard,
    output logic [NREG-1:0]      busy,
    output logic                 rf_wr_en,
    output logic [REG_SEL_W-1:0] rf_wr_reg,
    output logic [XLEN-1:0]      rf_wr_value
);

    logic            alu_elig;
    logic            gnt_alu;
    logic            gnt_ld;
    logic            granted;
    wb_req_t         win_req;
    logic [NREG-1:0] busy_d;
    logic            hz1;
    logic            hz2;

    // ALU is held off while its destination still has a load outstanding (WAW).
    always_comb begin
        alu_elig = wb.alu_valid && !(busy[wb.alu_rd] && (wb.alu_rd != '0));
    end

    rr_arbiter2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req_alu (alu_elig),
        .req_ld  (wb.ld_valid),
        .gnt_alu (gnt_alu),
        .gnt_ld  (gnt_ld)
    );

    // Handshake readies and winning payload select.
    always_comb begin
        wb.alu_ready = gnt_alu;
        wb.ld_ready  = gnt_ld;
        granted      = gnt_alu || gnt_ld;
        if (gnt_ld) begin
            win_req.rd   = wb.ld_rd;
            win_req.data = wb.ld_data;
        end else begin
            win_req.rd   = wb.alu_rd;
            win_req.data = wb.alu_data;
        end
    end

    // Write stage: one cycle from accept to write enable; x0 writes are swallowed.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_wr_en    <= 1'b0;
            rf_wr_reg   <= '0;
            rf_wr_value <= '0;
        end else if (granted) begin
            rf_wr_en    <= (win_req.rd != '0);
            rf_wr_reg   <= win_req.rd;
            rf_wr_value <= win_req.data;
        end else begin
            rf_wr_en    <= 1'b0;
        end
    end

    // Scoreboard next state: writeback clears, issue sets, set wins on collision.
    always_comb begin
        busy_d = busy;
        if (gnt_ld) begin
            busy_d[wb.ld_rd] = 1'b0;
        end
        if (ld_issue && (ld_issue_rd != '0)) begin
            busy_d[ld_issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_d;
        end
    end

    // Read hazard covers outstanding loads and the write still in flight.
    always_comb begin
        hz1    = (rs1_sel != '0) && (busy[rs1_sel] || (rf_wr_en && (rf_wr_reg == rs1_sel)));
        hz2    = (rs2_sel != '0) && (busy[rs2_sel] || (rf_wr_en && (rf_wr_reg == rs2_sel)));
        hazard = hz1 || hz2;
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter.
`timescale 1ns/1ps
module tb_regfile_write_arbiter;

    logic        clk;
    logic        rst;
    logic        ld_issue;
    logic [3:0]  ld_issue_rd;
    logic [3:0]  rs1_sel;
    logic [3:0]  rs2_sel;
    logic        hazard;
    logic [15:0] busy;
    logic        rf_wr_en;
    logic [3:0]  rf_wr_reg;
    logic [31:0] rf_wr_value;

    int checks;
    int errors;

    regfile_write_arbiter_if bus ();

    regfile_write_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .wb          (bus.slave),
        .ld_issue    (ld_issue),
        .ld_issue_rd (ld_issue_rd),
        .rs1_sel     (rs1_sel),
        .rs2_sel     (rs2_sel),
        .hazard      (hazard),
        .busy        (busy),
        .rf_wr_en    (rf_wr_en),
        .rf_wr_reg   (rf_wr_reg),
        .rf_wr_value (rf_wr_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; inputs change and outputs are sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.alu_valid = 1'b0;
        bus.alu_rd    = 4'd0;
        bus.alu_data  = 32'd0;
        bus.ld_valid  = 1'b0;
        bus.ld_rd     = 4'd0;
        bus.ld_data   = 32'd0;
        ld_issue      = 1'b0;
        ld_issue_rd   = 4'd0;
        rs1_sel       = 4'd0;
        rs2_sel       = 4'd0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 4'd5;
        bus.alu_data  = 32'hAAAA_5555;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (bus.alu_ready !== 1'b0) begin
                errors++;
                $display("FAIL reset_alu_ready got %b want 0", bus.alu_ready);
            end
            checks++;
            if (rf_wr_en !== 1'b0 || busy !== 16'h0000) begin
                errors++;
                $display("FAIL reset_state got en=%b busy=%h want en=0 busy=0000", rf_wr_en, busy);
            end
        end
        rst = 1'b0;
        bus.alu_data = 32'h1234_5678;
        #1;
        checks++;
        if (bus.alu_ready !== 1'b1) begin
            errors++;
            $display("FAIL first_alu_ready got %b want 1", bus.alu_ready);
        end
        tick();
        bus.alu_valid = 1'b0;
        checks++;
        if (rf_wr_en !== 1'b1 || rf_wr_reg !== 4'd5 || rf_wr_value !== 32'h1234_5678) begin
            errors++;
            $display("FAIL first_write got en=%b reg=%0d val=%h want en=1 reg=5 val=12345678",
                     rf_wr_en, rf_wr_reg, rf_wr_value);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_reg [4];
        exp_reg[0] = 4'd4; exp_reg[1] = 4'd3; exp_reg[2] = 4'd4; exp_reg[3] = 4'd3;
        bus.alu_valid = 1'b1; bus.alu_rd = 4'd3; bus.alu_data = 32'h0000_0333;
        bus.ld_valid  = 1'b1; bus.ld_rd  = 4'd4; bus.ld_data  = 32'h0000_0444;
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.ld_ready !== (exp_reg[i] == 4'd4) || bus.alu_ready !== (exp_reg[i] == 4'd3)) begin
                errors++;
                $display("FAIL rr_ready[%0d] got alu=%b ld=%b want alu=%b ld=%b", i,
                         bus.alu_ready, bus.ld_ready, exp_reg[i] == 4'd3, exp_reg[i] == 4'd4);
            end
            tick();
            checks++;
            if (rf_wr_en !== 1'b1 || rf_wr_reg !== exp_reg[i]) begin
                errors++;
                $display("FAIL rr_reg[%0d] got en=%b reg=%0d want en=1 reg=%0d", i,
                         rf_wr_en, rf_wr_reg, exp_reg[i]);
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_scoreboard_waw();
        ld_issue = 1'b1; ld_issue_rd = 4'd7;
        tick();
        ld_issue = 1'b0;
        rs1_sel = 4'd7;
        #1;
        checks++;
        if (busy !== 16'h0080 || hazard !== 1'b1) begin
            errors++;
            $display("FAIL sb_set got busy=%h hazard=%b want busy=0080 hazard=1", busy, hazard);
        end
        bus.alu_valid = 1'b1; bus.alu_rd = 4'd7; bus.alu_data = 32'h0000_0077;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (bus.alu_ready !== 1'b0) begin
                errors++;
                $display("FAIL waw_block[%0d] got alu_ready=%b want 0", i, bus.alu_ready);
            end
            tick();
        end
        bus.ld_valid = 1'b1; bus.ld_rd = 4'd7; bus.ld_data = 32'h0000_DEAD;
        #1;
        checks++;
        if (bus.ld_ready !== 1'b1 || bus.alu_ready !== 1'b0) begin
            errors++;
            $display("FAIL waw_ld_grant got ld=%b alu=%b want ld=1 alu=0", bus.ld_ready, bus.alu_ready);
        end
        tick();
        bus.ld_valid = 1'b0;
        #1;
        checks++;
        if (rf_wr_en !== 1'b1 || rf_wr_reg !== 4'd7 || rf_wr_value !== 32'h0000_DEAD || busy !== 16'h0000) begin
            errors++;
            $display("FAIL waw_ld_write got en=%b reg=%0d val=%h busy=%h want en=1 reg=7 val=0000dead busy=0000",
                     rf_wr_en, rf_wr_reg, rf_wr_value, busy);
        end
        checks++;
        if (bus.alu_ready !== 1'b1) begin
            errors++;
            $display("FAIL waw_release got alu_ready=%b want 1", bus.alu_ready);
        end
        tick();
        bus.alu_valid = 1'b0;
        rs1_sel = 4'd0;
        checks++;
        if (rf_wr_en !== 1'b1 || rf_wr_reg !== 4'd7 || rf_wr_value !== 32'h0000_0077) begin
            errors++;
            $display("FAIL waw_alu_write got en=%b reg=%0d val=%h want en=1 reg=7 val=00000077",
                     rf_wr_en, rf_wr_reg, rf_wr_value);
        end
        tick();
    endtask

    task automatic test_inflight_hazard();
        bus.alu_valid = 1'b1; bus.alu_rd = 4'd9; bus.alu_data = 32'h0000_0099;
        #1;
        checks++;
        if (bus.alu_ready !== 1'b1 || hazard !== 1'b0) begin
            errors++;
            $display("FAIL inflight_accept got ready=%b hazard=%b want ready=1 hazard=0", bus.alu_ready, hazard);
        end
        tick();
        bus.alu_valid = 1'b0;
        rs2_sel = 4'd9;
        #1;
        checks++;
        if (hazard !== 1'b1) begin
            errors++;
            $display("FAIL inflight_hazard got %b want 1", hazard);
        end
        tick();
        checks++;
        if (hazard !== 1'b0) begin
            errors++;
            $display("FAIL inflight_clear got %b want 0", hazard);
        end
        rs2_sel = 4'd0;
    endtask

    task automatic test_x0();
        bus.alu_valid = 1'b1; bus.alu_rd = 4'd0; bus.alu_data = 32'h0000_0005;
        ld_issue = 1'b1; ld_issue_rd = 4'd0;
        #1;
        checks++;
        if (bus.alu_ready !== 1'b1) begin
            errors++;
            $display("FAIL x0_ready got %b want 1", bus.alu_ready);
        end
        tick();
        bus.alu_valid = 1'b0;
        ld_issue = 1'b0;
        checks++;
        if (rf_wr_en !== 1'b0 || busy !== 16'h0000) begin
            errors++;
            $display("FAIL x0_effect got en=%b busy=%h want en=0 busy=0000", rf_wr_en, busy);
        end
    endtask

    task automatic test_set_clear_and_reset();
        ld_issue = 1'b1; ld_issue_rd = 4'd2;
        tick();
        checks++;
        if (busy !== 16'h0004) begin
            errors++;
            $display("FAIL sc_set got busy=%h want 0004", busy);
        end
        // Second issue to an already busy register keeps it busy.
        tick();
        rs2_sel = 4'd2;
        #1;
        checks++;
        if (busy !== 16'h0004 || hazard !== 1'b1) begin
            errors++;
            $display("FAIL sc_reissue got busy=%h hazard=%b want busy=0004 hazard=1", busy, hazard);
        end
        rs2_sel = 4'd0;
        bus.ld_valid = 1'b1; bus.ld_rd = 4'd2; bus.ld_data = 32'h0000_0222;
        #1;
        checks++;
        if (bus.ld_ready !== 1'b1) begin
            errors++;
            $display("FAIL sc_ld_ready got %b want 1", bus.ld_ready);
        end
        tick();
        ld_issue = 1'b0;
        checks++;
        if (busy !== 16'h0004 || rf_wr_en !== 1'b1 || rf_wr_reg !== 4'd2) begin
            errors++;
            $display("FAIL sc_collide got busy=%h en=%b reg=%0d want busy=0004 en=1 reg=2", busy, rf_wr_en, rf_wr_reg);
        end
        // Reset while both sources request: no grant, state cleared.
        bus.alu_valid = 1'b1; bus.alu_rd = 4'd6; bus.alu_data = 32'h0000_0666;
        bus.ld_rd = 4'd8; bus.ld_data = 32'h0000_0888;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.alu_ready !== 1'b0 || bus.ld_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_ready got alu=%b ld=%b want 0 0", bus.alu_ready, bus.ld_ready);
        end
        tick();
        rst = 1'b0;
        checks++;
        if (busy !== 16'h0000 || rf_wr_en !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_state got busy=%h en=%b want busy=0000 en=0", busy, rf_wr_en);
        end
        #1;
        checks++;
        if (bus.ld_ready !== 1'b1 || bus.alu_ready !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_rr got ld=%b alu=%b want ld=1 alu=0", bus.ld_ready, bus.alu_ready);
        end
        tick();
        idle_inputs();
        checks++;
        if (rf_wr_en !== 1'b1 || rf_wr_reg !== 4'd8 || rf_wr_value !== 32'h0000_0888) begin
            errors++;
            $display("FAIL post_reset_write got en=%b reg=%0d val=%h want en=1 reg=8 val=00000888",
                     rf_wr_en, rf_wr_reg, rf_wr_value);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_round_robin();
        test_scoreboard_waw();
        test_inflight_hazard();
        test_x0();
        test_set_clear_and_reset();
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the single register-file write port between two writeback sources: the ALU/execute stage and the load unit (memory read completion).
- Keeps a per-register scoreboard of outstanding loads. Flags read hazards for the decode stage and blocks ALU writes that would race a pending load (WAW).
- Sits between the execute/load units and the 16-entry RV32E register file. It drives that file's write_register, write_value and wr_en.

Parameters:
- XLEN, 32, data width of register values.
- NREG, 16, number of architectural registers (select width fixed at 4 bits).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- alu_valid  in  1  ALU result available.
- alu_rd  in  4  ALU destination register.
- alu_data  in  XLEN  ALU result.
- alu_ready  out  1  ALU result accepted this cycle.
- ld_valid  in  1  load data available.
- ld_rd  in  4  load destination register.
- ld_data  in  XLEN  load data.
- ld_ready  out  1  load data accepted this cycle.
- ld_issue  in  1  load issued to memory; reserves ld_issue_rd.
- ld_issue_rd  in  4  destination of the issued load.
- rs1_sel  in  4  decode read select 1.
- rs2_sel  in  4  decode read select 2.
- hazard  out  1  decode must stall (combinational).
- busy  out  NREG  scoreboard bit per register.
- rf_wr_en  out  1  register-file write enable (registered).
- rf_wr_reg  out  4  register-file write select (registered).
- rf_wr_value  out  XLEN  register-file write data (registered).

Behaviour:
- Reset: on the rising edge with rst=1:
  - busy=0, rf_wr_en=0, rf_wr_reg=0, rf_wr_value=0.
  - last_grant=ALU, so the load unit wins the first conflict.
  - alu_ready and ld_ready are 0 while rst=1.
  - A reset mid-operation discards any pending grant and clears all reservations.
- Eligibility:
  - Load eligible = ld_valid.
  - ALU eligible = alu_valid && !(busy[alu_rd] && alu_rd!=0), i.e. blocked by WAW.
- Arbitration:
  - One grant per cycle.
  - If both are eligible, the source not granted last time wins (round-robin on a 1-bit last_grant).
  - last_grant updates only on a grant.
  - alu_ready and ld_ready are combinational grant signals. A transfer happens when valid && ready.
- Write stage latency:
  - On a grant, the next edge loads rf_wr_en=1, rf_wr_reg=rd, rf_wr_value=data.
  - With no grant, rf_wr_en=0 and reg/value hold their previous values.
  - Result: exactly 1 cycle from accept to write enable.
- x0 handling:
  - A granted transfer with rd=0 is accepted but produces rf_wr_en=0.
  - ld_issue with rd=0 sets no busy bit.
- Scoreboard:
  - ld_issue sets busy[ld_issue_rd].
  - A granted load transfer clears busy[ld_rd].
  - Same-cycle set and clear of the same register: set wins (new load outstanding).
  - busy[0] is always 0.
  - One outstanding load per register. A second ld_issue to a busy rd leaves it busy.
- Hazard:
  - hazard=1 if any read select sN (N=1,2) satisfies sN!=0 && (busy[sN] || (rf_wr_en && rf_wr_reg==sN)).
  - The second term covers the write still in flight to the register file.
- Same-destination conflict:
  - When the ALU and the load target the same rd in the same cycle, ALU eligibility already excludes the case where rd is busy.
  - Otherwise the arbiter order defines the write order, and the later grant's value persists.

Decomposition:
- Shared package regfile_pkg:
  - REG_SEL_W=4 and NREG=16.
  - Enum grant_src_t {GRANT_ALU, GRANT_LD}.
- One natural sub-module: rr_arbiter2 (2-input round-robin with last_grant state).
- The scoreboard and write stage stay in the top module.

Test Plan:
- Reset: assert rst 2 cycles with alu_valid=1 -> rf_wr_en=0, busy=0, alu_ready=0. After release, ALU write rd=5, data=0x12345678 -> next cycle rf_wr_en=1, reg=5, value=0x12345678.
- Round-robin: both valid continuously (alu_rd=3, ld_rd=4) -> grants alternate LD, ALU, LD, ALU. The rf_wr_reg sequence is 4,3,4,3.
- Scoreboard/WAW:
  - ld_issue rd=7 -> busy[7]=1. rs1_sel=7 -> hazard=1.
  - alu_valid rd=7 -> alu_ready=0 until the load writes back 0xDEAD.
  - Then busy[7]=0, and the ALU is granted the next cycle.
- In-flight hazard: ALU write rd=9 accepted. The following cycle rs2_sel=9 -> hazard=1. The cycle after -> hazard=0.
- x0: ALU write rd=0 -> alu_ready=1, rf_wr_en stays 0. ld_issue rd=0 -> busy unchanged.
- Set/clear collision: load writeback rd=2 and ld_issue rd=2 in the same cycle -> busy[2]=1 afterwards. rst mid-sequence -> busy=0 next cycle.
